// File: rtl/aes_bist_ctrl_pkg.sv
// Shared types and defaults for the AES BIST run-side controller.
package aes_bist_pkg;

    // Controller states; PASS and FAIL are terminal until the next start.
    typedef enum logic [2:0] {
        IDLE,
        RST_CORE,
        RUN,
        CAPTURE,
        COMPARE,
        PASS,
        FAIL
    } bist_state_e;

    localparam logic [7:0]  DEF_GOLDEN_SIG = 8'hC0;
    localparam int unsigned DEF_TIMEOUT    = 4096;

endpackage

// File: rtl/aes_bist_ctrl_if.sv
// Wrapper-side link of the BIST controller: mode/enable/reset out, signature and status back.
interface aes_bist_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             is_bist;
    logic             en_lsfr_misr;
    logic             core_rst;
    logic [WIDTH-1:0] dut_sig;
    logic             dut_done;
    logic             dut_vld;

    // Controller drives mode/enable/reset and observes the wrapper.
    modport master (
        output is_bist, en_lsfr_misr, core_rst,
        input  dut_sig, dut_done, dut_vld
    );

    // BIST wrapper side.
    modport slave (
        input  is_bist, en_lsfr_misr, core_rst,
        output dut_sig, dut_done, dut_vld
    );
endinterface

// File: rtl/aes_bist_ctrl_cnt.sv
// Clear/enable cycle counter; tc flags the final count TERM-1, so an
// enable window that starts from a cleared counter lasts TERM cycles.
module bist_cycle_counter #(
    parameter int unsigned TERM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int unsigned CW = (TERM > 2) ? $clog2(TERM) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + CW'(1);
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == CW'(TERM - 1));
endmodule

// File: rtl/aes_bist_ctrl.sv
// AES BIST run-side controller: resets the core, runs LFSR/MISR until DONE,
// captures the signature and compares it against the golden value.
// Optional d_vld pulse-count check: define AES_BIST_VLD_CHECK_EN.
module aes_bist_ctrl
    import aes_bist_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] GOLDEN_SIG = WIDTH'(DEF_GOLDEN_SIG),
    parameter int unsigned      RST_CYCLES = 4,
    parameter int unsigned      TIMEOUT    = DEF_TIMEOUT
`ifdef AES_BIST_VLD_CHECK_EN
    ,
    parameter int unsigned      EXP_VLD    = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    aes_bist_if.master        bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [WIDTH-1:0]  sig_out,
    output logic [7:0]        vld_cnt
);
    bist_state_e      state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic             to_q, to_d;
    logic             rst_tc, wd_tc;
    logic             vld_ok;

    // Core-reset length: counter sits cleared outside RST_CORE.
    bist_cycle_counter #(.TERM(RST_CYCLES)) u_rst_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state_q != RST_CORE),
        .en  (state_q == RST_CORE),
        .tc  (rst_tc)
    );

    // RUN watchdog: tc on the TIMEOUT-th RUN cycle.
    bist_cycle_counter #(.TERM(TIMEOUT)) u_wd_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state_q != RUN),
        .en  (state_q == RUN),
        .tc  (wd_tc)
    );

`ifdef AES_BIST_VLD_CHECK_EN
    logic [7:0] vld_q, vld_d;

    // Saturating d_vld pulse count during RUN; cleared by an accepted start.
    always_comb begin
        vld_d = vld_q;
        if ((state_q == IDLE || state_q == PASS || state_q == FAIL) && start)
            vld_d = '0;
        else if (state_q == RUN && bus.dut_vld && vld_q != 8'hFF)
            vld_d = vld_q + 8'd1;
    end

    // Pulse-count register.
    always_ff @(posedge clk) begin
        if (!rst) vld_q <= '0;
        else      vld_q <= vld_d;
    end

    assign vld_cnt = vld_q;
    assign vld_ok  = (vld_q == 8'(EXP_VLD));
`else
    assign vld_cnt = '0;
    assign vld_ok  = 1'b1;
`endif

    // Next state plus signature/timeout flag updates.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        to_d    = to_q;
        case (state_q)
            IDLE, PASS, FAIL: begin
                if (start) begin
                    state_d = RST_CORE;
                    sig_d   = '0;
                    to_d    = 1'b0;
                end
            end
            RST_CORE: if (rst_tc) state_d = RUN;
            RUN: begin
                // DONE takes priority over a watchdog expiring the same cycle.
                if (bus.dut_done) begin
                    state_d = CAPTURE;
                end else if (wd_tc) begin
                    state_d = FAIL;
                    to_d    = 1'b1;
                end
            end
            CAPTURE: begin
                sig_d   = bus.dut_sig;
                state_d = COMPARE;
            end
            COMPARE: state_d = (sig_q == GOLDEN_SIG && vld_ok) ? PASS : FAIL;
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset abandons any run without a verdict.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sig_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            to_q    <= to_d;
        end
    end

    assign busy             = (state_q == RST_CORE) || (state_q == RUN) ||
                              (state_q == CAPTURE)  || (state_q == COMPARE);
    assign bus.is_bist      = busy;
    assign bus.en_lsfr_misr = (state_q == RUN);
    assign bus.core_rst     = (state_q == RST_CORE);
    assign done             = (state_q == PASS) || (state_q == FAIL);
    assign pass             = (state_q == PASS);
    assign fail             = (state_q == FAIL);
    assign timeout          = to_q;
    assign sig_out          = sig_q;
endmodule

// File: tb/tb_aes_bist_ctrl.sv
// Directed bench for aes_bist_ctrl (TIMEOUT=64, RST_CYCLES=4).
module tb_aes_bist_ctrl;
`ifdef AES_BIST_VLD_CHECK_EN
    localparam logic [7:0] EXP_CNT = 8'd16;
`else
    localparam logic [7:0] EXP_CNT = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, pass, fail, timeout;
    logic [7:0] sig_out, vld_cnt;
    int         n_tests = 0;
    int         n_fail  = 0;

    aes_bist_if #(.WIDTH(8)) bif ();

    aes_bist_ctrl #(.TIMEOUT(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bif),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .fail    (fail),
        .timeout (timeout),
        .sig_out (sig_out),
        .vld_cnt (vld_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {8'd0, bif.is_bist, bif.en_lsfr_misr, bif.core_rst, busy, done, pass,
                fail, timeout, sig_out, vld_cnt};
    endfunction

    // Pulse start, then model the core: DONE on the n_done-th RUN cycle
    // (0 = never), d_vld on the first n_vld RUN cycles, optional start
    // re-pulse during RUN. Returns cycle counts and the first-cycle flags.
    task automatic run_bist(input logic [7:0] sig, input int n_done, input int n_vld,
                            input int start_at, output int en_c, output int rst_c,
                            output int busy_c, output logic [11:0] first);
        bit fin = 0;
        en_c = 0; rst_c = 0; busy_c = 0;
        bif.dut_sig = sig;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        first = {done, pass, fail, timeout, sig_out};
        for (int i = 0; i < 300 && !fin; i++) begin
            if (i > 0) @(negedge clk);
            start = 1'b0; bif.dut_done = 1'b0; bif.dut_vld = 1'b0;
            if (done) begin
                fin = 1;
            end else begin
                if (busy) busy_c++;
                if (bif.core_rst) rst_c++;
                if (bif.en_lsfr_misr) begin
                    en_c++;
                    bif.dut_done = (en_c == n_done);
                    bif.dut_vld  = (en_c <= n_vld);
                    start        = (en_c == start_at);
                end
            end
        end
        if (!fin) chk("run_bound", 32'd0, 32'd1);
    endtask

    initial begin
        int en_c, rst_c, busy_c;
        logic [11:0] first;
        bit seen;
        bif.dut_sig = 8'h00; bif.dut_done = 1'b0; bif.dut_vld = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs(), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_outs", all_outs(), 32'd0);

        // 1: golden signature after 20 RUN cycles
        run_bist(8'hC0, 20, 16, 0, en_c, rst_c, busy_c, first);
        chk("t1_pass", {pass, fail, timeout}, 3'b100);
        chk("t1_sig", sig_out, 8'hC0);
        chk("t1_en_cycles", en_c, 20);
        chk("t1_rst_cycles", rst_c, 4);
        chk("t1_busy_cycles", busy_c, 26);
        chk("t1_is_bist_after", bif.is_bist, 1'b0);
        chk("t1_vld_cnt", vld_cnt, EXP_CNT);

        // 2: wrong signature
        run_bist(8'h3A, 20, 16, 0, en_c, rst_c, busy_c, first);
        chk("t2_first_flags", first, 12'h000);
        chk("t2_fail", {pass, fail, timeout}, 3'b010);
        chk("t2_sig", sig_out, 8'h3A);

        // 3: watchdog, DONE never arrives
        run_bist(8'hC0, 0, 16, 0, en_c, rst_c, busy_c, first);
        chk("t3_fail_to", {done, pass, fail, timeout}, 4'b1011);
        chk("t3_en_cycles", en_c, 64);
        chk("t3_is_bist_after", {bif.is_bist, bif.en_lsfr_misr, busy}, 3'b000);
        chk("t3_sig", sig_out, 8'h00);

        // Restart after timeout clears the sticky flags
        run_bist(8'hC0, 20, 16, 0, en_c, rst_c, busy_c, first);
        chk("restart_first_flags", first, 12'h000);
        chk("restart_pass", {pass, fail, timeout}, 3'b100);

        // 4: start during RUN is ignored; second start after PASS
        run_bist(8'hC0, 20, 16, 5, en_c, rst_c, busy_c, first);
        chk("t4_pass", {pass, fail, timeout}, 3'b100);
        chk("t4_en_cycles", en_c, 20);
        chk("t4_busy_cycles", busy_c, 26);
        run_bist(8'hC0, 20, 16, 0, en_c, rst_c, busy_c, first);
        chk("t4_second_first_flags", first, 12'h000);
        chk("t4_second_rst_cycles", rst_c, 4);
        chk("t4_second_pass", pass, 1'b1);

        // 5: reset mid-RUN abandons the run
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        en_c = 0; seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bif.en_lsfr_misr) en_c++;
            seen = (en_c == 10);
        end
        chk("t5_reached_run", seen, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_reset_outs", all_outs(), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_no_done", {done, busy, bif.is_bist}, 3'b000);

        // 6: d_vld pulse-count check
        run_bist(8'hC0, 20, 15, 0, en_c, rst_c, busy_c, first);
`ifdef AES_BIST_VLD_CHECK_EN
        chk("t6_vld15_fail", {pass, fail}, 2'b01);
        chk("t6_vld15_cnt", vld_cnt, 8'd15);
`else
        chk("t6_vld15_pass", {pass, fail}, 2'b10);
        chk("t6_vld15_cnt", vld_cnt, 8'd0);
`endif
        run_bist(8'hC0, 20, 16, 0, en_c, rst_c, busy_c, first);
        chk("t6_vld16_pass", {pass, fail}, 2'b10);
        chk("t6_vld16_cnt", vld_cnt, EXP_CNT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
